// File: rtl/fitness_evaluator.sv
// Reduces the masked per-output error sums of one processed chromosome to a fitness value,
// hands the done-feedback pulse back upstream and tracks the best chromosome of the generation.
module fitness_evaluator #(
    parameter int NUM_OUTPUTS = 8,
    parameter int SUM_WIDTH   = 32,
    parameter int ID_WIDTH    = 8,
    parameter int FIT_WIDTH   = SUM_WIDTH + $clog2(NUM_OUTPUTS)
) (
    input  logic                             iClock,
    input  logic                             iReset,
    input  logic                             iDoneProcessing,
    input  logic [NUM_OUTPUTS*SUM_WIDTH-1:0] iErrorSums,
    input  logic [NUM_OUTPUTS-1:0]           iOutputMask,
    input  logic [ID_WIDTH-1:0]              iChromId,
    input  logic                             iNewGeneration,
    input  logic                             iFitnessAck,
    output logic                             oDoneProcessingFeedback,
    output logic                             oFitnessValid,
    output logic [FIT_WIDTH-1:0]             oFitness,
    output logic [ID_WIDTH-1:0]              oChromId,
    output logic                             oPerfect,
    output logic [FIT_WIDTH-1:0]             oBestFitness,
    output logic [ID_WIDTH-1:0]              oBestChromId,
    output logic                             oBestValid,
    output logic                             oBusy
);

    localparam int LANE_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(NUM_OUTPUTS - 1);

    typedef enum logic [2:0] {IDLE, SUM, COMPARE, ACK, PRESENT} state_t;

    state_t                           state;
    logic [NUM_OUTPUTS*SUM_WIDTH-1:0] sums;
    logic [NUM_OUTPUTS-1:0]           mask;
    logic [ID_WIDTH-1:0]              chrom_id;
    logic [FIT_WIDTH-1:0]             acc;
    logic [LANE_WIDTH-1:0]            lane;
    logic [SUM_WIDTH-1:0]             lane_sum;

    always_comb begin
        lane_sum = '0;
        if (mask[lane])
            lane_sum = sums[int'(lane)*SUM_WIDTH +: SUM_WIDTH];
    end

    assign oBusy = (state != IDLE);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state                   <= IDLE;
            sums                    <= '0;
            mask                    <= '0;
            chrom_id                <= '0;
            acc                     <= '0;
            lane                    <= '0;
            oDoneProcessingFeedback <= 1'b0;
            oFitnessValid           <= 1'b0;
            oFitness                <= '0;
            oChromId                <= '0;
            oPerfect                <= 1'b0;
            oBestFitness            <= '1;
            oBestChromId            <= '0;
            oBestValid              <= 1'b0;
        end else begin
            if (iNewGeneration) begin
                oBestFitness <= '1;
                oBestChromId <= '0;
                oBestValid   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (iDoneProcessing) begin
                        sums     <= iErrorSums;
                        mask     <= iOutputMask;
                        chrom_id <= iChromId;
                        acc      <= '0;
                        lane     <= '0;
                        state    <= SUM;
                    end
                end
                SUM: begin
                    acc  <= acc + FIT_WIDTH'(lane_sum);
                    lane <= lane + 1'b1;
                    if (lane == LAST_LANE)
                        state <= COMPARE;
                end
                COMPARE: begin
                    oFitness <= acc;
                    oChromId <= chrom_id;
                    oPerfect <= (acc == '0);
                    // A coincident new-generation clear is overridden here, making this result the new best.
                    if (iNewGeneration || !oBestValid || acc < oBestFitness) begin
                        oBestFitness <= acc;
                        oBestChromId <= chrom_id;
                        oBestValid   <= 1'b1;
                    end
                    oDoneProcessingFeedback <= 1'b1;
                    state                   <= ACK;
                end
                ACK: begin
                    oDoneProcessingFeedback <= 1'b0;
                    oFitnessValid           <= 1'b1;
                    state                   <= PRESENT;
                end
                PRESENT: begin
                    if (iFitnessAck) begin
                        oFitnessValid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
